// File: rtl/ctrl_pkg.sv
// Shared types, encodings and the opcode-to-ALU table for the multicycle
// controller of the 16-bit processor.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_SH, S_EXEC_SLT,
    S_BR, S_JMP, S_JR_ADDR, S_JR, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_ALU, S_WB_MEM, S_WB_IMM, S_WB_COPY, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_COPY, CL_JR, CL_I, CL_BEQ, CL_BNE, CL_J,
    CL_LW, CL_SW, CL_LI, CL_SH, CL_SLT, CL_ILL
  } class_t;

  localparam logic [3:0] OP_RTYPE = 4'h0, OP_ADDI = 4'h1, OP_BEQ  = 4'h2, OP_BNE  = 4'h3;
  localparam logic [3:0] OP_J     = 4'h4, OP_LW   = 4'h5, OP_SW   = 4'h6, OP_LI   = 4'h8;
  localparam logic [3:0] OP_ANDI  = 4'h9, OP_ORI  = 4'hA, OP_XORI = 4'hB, OP_SLL  = 4'hC;
  localparam logic [3:0] OP_SRL   = 4'hD, OP_SRA  = 4'hE, OP_SLTI = 4'hF;
  localparam logic [3:0] FN_COPY  = 4'h6, FN_JR   = 4'h7;

  localparam logic [1:0] BSRC_REG = 2'b00, BSRC_IMM = 2'b01, BSRC_PC1 = 2'b10, BSRC_SHAMT = 2'b11;
  localparam logic [1:0] WDAT_MEM = 2'b00, WDAT_ALU = 2'b01, WDAT_A   = 2'b10, WDAT_IMM   = 2'b11;
  localparam logic [1:0] JMP_NONE = 2'b00, JMP_J    = 2'b01, JMP_JR   = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_SLT = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;

  typedef struct packed {
    logic       pc_wrt;
    logic       ir_wrt;
    logic       a_wrt;
    logic       b_wrt;
    logic       alu_wrt;
    logic       reg_wrt;
    logic       mem_wrt;
    logic       mem_req;
    logic       mem_adrs_slct;
    logic       branch;
    logic       bne_sel;
    logic [1:0] jump;
    logic       use_first_reg;
    logic       use_reg;
    logic [1:0] b_src;
    logic [1:0] wdat;
    logic       illegal;
    logic       instr_done;
  } ctrl_out_t;

  // R-type passes the function field straight through as the ALU select.
  function automatic logic [3:0] op_alu(input logic [3:0] op, input logic [3:0] fn);
    case (op)
      OP_RTYPE:              return fn;
      OP_BEQ, OP_BNE:        return ALU_SUB;
      OP_ANDI:               return ALU_AND;
      OP_ORI:                return ALU_OR;
      OP_XORI:               return ALU_XOR;
      OP_SLL:                return ALU_SLL;
      OP_SRL:                return ALU_SRL;
      OP_SRA:                return ALU_SRA;
      OP_SLTI:               return ALU_SLT;
      default:               return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: opcode/function field to dispatch
// class and ALU operation select.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 4,
  parameter int ALUOP_W = 4
) (
  input  logic [OP_W-1:0]    i_op,
  input  logic [FUNC_W-1:0]  i_func,
  output class_t             o_class,
  output logic [ALUOP_W-1:0] o_alu_op
);

  logic       w_hi;
  logic [3:0] w_op4;
  logic [3:0] w_fn4;

  // Any opcode bit above the 4-bit field makes the instruction illegal.
  if (OP_W > 4) begin : g_hi
    assign w_hi = |i_op[OP_W-1:4];
  end else begin : g_no_hi
    assign w_hi = 1'b0;
  end

  assign w_op4    = 4'(i_op);
  assign w_fn4    = 4'(i_func);
  assign o_alu_op = ALUOP_W'(op_alu(w_op4, w_fn4));

  always_comb begin
    o_class = CL_ILL;
    if (!w_hi) begin
      case (w_op4)
        OP_RTYPE: begin
          if (i_func == FUNC_W'(FN_COPY))    o_class = CL_COPY;
          else if (i_func == FUNC_W'(FN_JR)) o_class = CL_JR;
          else                               o_class = CL_R;
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: o_class = CL_I;
        OP_BEQ:                            o_class = CL_BEQ;
        OP_BNE:                            o_class = CL_BNE;
        OP_J:                              o_class = CL_J;
        OP_LW:                             o_class = CL_LW;
        OP_SW:                             o_class = CL_SW;
        OP_LI:                             o_class = CL_LI;
        OP_SLL, OP_SRL, OP_SRA:            o_class = CL_SH;
        OP_SLTI:                           o_class = CL_SLT;
        default:                           o_class = CL_ILL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller: fetch/decode/execute/memory/write-back FSM
// with memory handshake, illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int FUNC_W  = 4,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               mem_ready,
  output logic               pc_wrt,
  output logic               ir_wrt,
  output logic               a_wrt,
  output logic               b_wrt,
  output logic               alu_wrt,
  output logic               reg_wrt,
  output logic               mem_wrt,
  output logic               mem_req,
  output logic               mem_adrs_slct,
  output logic               branch,
  output logic               bne_sel,
  output logic [1:0]         jump,
  output logic               use_first_reg,
  output logic               use_reg,
  output logic [1:0]         b_src,
  output logic [1:0]         wdat,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic               instr_done,
  output logic [CNT_W-1:0]   retired
);

  // state          | meaning
  // FETCH/DECODE   | IR load (waits on mem_ready) / operand read + dispatch
  // EXEC_*/MEM_ADDR| ALU result into ALUout (R, I, shift, slti, address)
  // MEM_RD/MEM_WR  | data access, holds until mem_ready
  // WB_*/BR/JMP/JR | retire: write-back, branch or jump
  // JR_ADDR / TRAP | PC+1 into ALUout before JR / illegal opcode, parked

  state_t             r_state, w_next;
  logic               r_bne_sel;
  logic               r_store;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [CNT_W-1:0]   r_retired;
  class_t             w_class;
  logic [ALUOP_W-1:0] w_dec_alu;
  logic [ALUOP_W-1:0] w_alu_op;
  ctrl_out_t          w_out, w_gated;

  ctrl_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W)) u_decode (
    .i_op     (op),
    .i_func   (func),
    .o_class  (w_class),
    .o_alu_op (w_dec_alu)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_bne_sel <= 1'b0;
      r_store   <= 1'b0;
      r_alu_op  <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_bne_sel <= (w_class == CL_BNE);
        r_store   <= (w_class == CL_SW);
        r_alu_op  <= w_dec_alu;
      end
      if (w_out.instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_out    = '0;
    w_alu_op = '0;
    case (r_state)
      S_FETCH: begin
        w_out.mem_req = 1'b1;
        if (mem_ready) begin
          w_out.pc_wrt = 1'b1;
          w_out.ir_wrt = 1'b1;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: begin
        w_out.a_wrt         = 1'b1;
        w_out.b_wrt         = 1'b1;
        w_out.use_first_reg = !(w_class inside {CL_LI, CL_J, CL_ILL});
        w_out.use_reg       = w_class inside {CL_R, CL_BEQ, CL_BNE, CL_SW};
        case (w_class)
          CL_R:           w_next = S_EXEC_R;
          CL_COPY:        w_next = S_WB_COPY;
          CL_JR:          w_next = S_JR_ADDR;
          CL_I:           w_next = S_EXEC_I;
          CL_BEQ, CL_BNE: w_next = S_BR;
          CL_J:           w_next = S_JMP;
          CL_LW, CL_SW:   w_next = S_MEM_ADDR;
          CL_LI:          w_next = S_WB_IMM;
          CL_SH:          w_next = S_EXEC_SH;
          CL_SLT:         w_next = S_EXEC_SLT;
          default:        w_next = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_SH, S_EXEC_SLT: begin
        w_out.alu_wrt = 1'b1;
        w_alu_op      = r_alu_op;
        case (r_state)
          S_EXEC_R:  w_out.b_src = BSRC_REG;
          S_EXEC_SH: w_out.b_src = BSRC_SHAMT;
          default:   w_out.b_src = BSRC_IMM;
        endcase
        w_next = S_WB_ALU;
      end
      S_BR: begin
        w_out.branch     = 1'b1;
        w_out.bne_sel    = r_bne_sel;
        w_out.instr_done = 1'b1;
        w_alu_op         = r_alu_op;
        w_next           = S_FETCH;
      end
      S_JMP: begin
        w_out.jump       = JMP_J;
        w_out.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_JR_ADDR: begin
        w_out.b_src   = BSRC_PC1;
        w_out.alu_wrt = 1'b1;
        w_alu_op      = ALUOP_W'(ALU_ADD);
        w_next        = S_JR;
      end
      S_JR: begin
        w_out.jump       = JMP_JR;
        w_out.instr_done = 1'b1;
        w_next           = S_FETCH;
      end
      S_MEM_ADDR: begin
        w_out.b_src   = BSRC_IMM;
        w_out.alu_wrt = 1'b1;
        w_alu_op      = r_alu_op;
        w_next        = r_store ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_out.mem_req       = 1'b1;
        w_out.mem_adrs_slct = 1'b1;
        if (mem_ready) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        w_out.mem_req       = 1'b1;
        w_out.mem_adrs_slct = 1'b1;
        w_out.mem_wrt       = 1'b1;
        if (mem_ready) begin
          w_out.instr_done = 1'b1;
          w_next           = S_FETCH;
        end
      end
      S_WB_ALU, S_WB_MEM, S_WB_IMM, S_WB_COPY: begin
        w_out.reg_wrt    = 1'b1;
        w_out.instr_done = 1'b1;
        case (r_state)
          S_WB_ALU: w_out.wdat = WDAT_ALU;
          S_WB_MEM: w_out.wdat = WDAT_MEM;
          S_WB_IMM: w_out.wdat = WDAT_IMM;
          default:  w_out.wdat = WDAT_A;
        endcase
        w_next = S_FETCH;
      end
      S_TRAP:  w_out.illegal = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset forces every output low at once, independent of the clock.
  assign w_gated = reset ? w_out : '0;
  assign alu_op  = reset ? w_alu_op : '0;

  assign pc_wrt        = w_gated.pc_wrt;
  assign ir_wrt        = w_gated.ir_wrt;
  assign a_wrt         = w_gated.a_wrt;
  assign b_wrt         = w_gated.b_wrt;
  assign alu_wrt       = w_gated.alu_wrt;
  assign reg_wrt       = w_gated.reg_wrt;
  assign mem_wrt       = w_gated.mem_wrt;
  assign mem_req       = w_gated.mem_req;
  assign mem_adrs_slct = w_gated.mem_adrs_slct;
  assign branch        = w_gated.branch;
  assign bne_sel       = w_gated.bne_sel;
  assign jump          = w_gated.jump;
  assign use_first_reg = w_gated.use_first_reg;
  assign use_reg       = w_gated.use_reg;
  assign b_src         = w_gated.b_src;
  assign wdat          = w_gated.wdat;
  assign illegal       = w_gated.illegal;
  assign instr_done    = w_gated.instr_done;
  assign retired       = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-class latency, write-back selects,
// memory waits, trap, mid-instruction reset and counter wrap.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = '0;
  logic [3:0]  func = '0;
  logic        mem_ready = 1'b0;

  logic        pc_wrt, ir_wrt, a_wrt, b_wrt, alu_wrt, reg_wrt, mem_wrt, mem_req;
  logic        mem_adrs_slct, branch, bne_sel, use_first_reg, use_reg, illegal, instr_done;
  logic [1:0]  jump, b_src, wdat;
  logic [3:0]  alu_op;
  logic [31:0] retired;

  logic        d4_pc_wrt, d4_ir_wrt, d4_a_wrt, d4_b_wrt, d4_alu_wrt, d4_reg_wrt, d4_mem_wrt;
  logic        d4_mem_req, d4_mem_adrs_slct, d4_branch, d4_bne_sel, d4_use_first_reg;
  logic        d4_use_reg, d4_illegal, d4_instr_done;
  logic [1:0]  d4_jump, d4_b_src, d4_wdat;
  logic [3:0]  d4_alu_op;
  logic [3:0]  d4_retired;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;

  wire [24:0] all_out = {pc_wrt, ir_wrt, a_wrt, b_wrt, alu_wrt, reg_wrt, mem_wrt, mem_req,
                         mem_adrs_slct, branch, bne_sel, jump, use_first_reg, use_reg,
                         b_src, wdat, alu_op, illegal, instr_done};
  wire [10:0] enables = {pc_wrt, ir_wrt, a_wrt, b_wrt, alu_wrt, reg_wrt, mem_wrt, mem_req,
                         branch, jump};

  always #5 CLK = ~CLK;

  multicycle_ctrl dut (
    .CLK(CLK), .reset(reset), .op(op), .func(func), .mem_ready(mem_ready),
    .pc_wrt(pc_wrt), .ir_wrt(ir_wrt), .a_wrt(a_wrt), .b_wrt(b_wrt), .alu_wrt(alu_wrt),
    .reg_wrt(reg_wrt), .mem_wrt(mem_wrt), .mem_req(mem_req), .mem_adrs_slct(mem_adrs_slct),
    .branch(branch), .bne_sel(bne_sel), .jump(jump), .use_first_reg(use_first_reg),
    .use_reg(use_reg), .b_src(b_src), .wdat(wdat), .alu_op(alu_op), .illegal(illegal),
    .instr_done(instr_done), .retired(retired)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .op(op), .func(func), .mem_ready(mem_ready),
    .pc_wrt(d4_pc_wrt), .ir_wrt(d4_ir_wrt), .a_wrt(d4_a_wrt), .b_wrt(d4_b_wrt),
    .alu_wrt(d4_alu_wrt), .reg_wrt(d4_reg_wrt), .mem_wrt(d4_mem_wrt), .mem_req(d4_mem_req),
    .mem_adrs_slct(d4_mem_adrs_slct), .branch(d4_branch), .bne_sel(d4_bne_sel),
    .jump(d4_jump), .use_first_reg(d4_use_first_reg), .use_reg(d4_use_reg),
    .b_src(d4_b_src), .wdat(d4_wdat), .alu_op(d4_alu_op), .illegal(d4_illegal),
    .instr_done(d4_instr_done), .retired(d4_retired)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench at cycle 1 (FETCH) of a fresh run, inputs idle.
  task automatic do_reset();
    reset = 1'b0; mem_ready = 1'b0; op = '0; func = '0;
    repeat (2) step();
    reset = 1'b1;
    exp_retired = 0;
  endtask

  // Runs one instruction; answers mem_ready per the observed request phase.
  task automatic exec_instr(input logic [3:0] i_op, input logic [3:0] i_fn,
                            input int fwait, input int mwait, input bit scramble,
                            output int done_cyc, output logic s_reg, output logic [1:0] s_wdat,
                            output logic s_br, output logic s_bne, output logic [1:0] s_jump,
                            output logic s_mwrt, output int mem_cyc);
    int fw = fwait;
    int mw = mwait;
    done_cyc = -1; mem_cyc = 0;
    s_reg = 0; s_wdat = 0; s_br = 0; s_bne = 0; s_jump = 0; s_mwrt = 0;
    op = i_op; func = i_fn;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      if (scramble && c >= 3) begin op = 4'h7; func = 4'h7; end
      if (mem_req && !mem_adrs_slct) begin
        mem_ready = (fw == 0);
        if (fw > 0) fw--;
      end else if (mem_req) begin
        mem_ready = (mw == 0);
        if (mw > 0) mw--;
        mem_cyc++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (instr_done) begin
        done_cyc = c;
        s_reg = reg_wrt; s_wdat = wdat; s_br = branch; s_bne = bne_sel;
        s_jump = jump; s_mwrt = mem_wrt;
      end
      step();
    end
    mem_ready = 1'b0;
    exp_retired++;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; op = 4'h1;
    repeat (2) step();
    checks++;
    if (all_out !== 25'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", all_out); end
    checks++;
    if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d want=0", retired); end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_adrs_slct, pc_wrt, ir_wrt} !== 4'b1000) begin
      failures++; $display("FAIL fetch_wait got=%b want=1000", {mem_req, mem_adrs_slct, pc_wrt, ir_wrt});
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({pc_wrt, ir_wrt} !== 2'b11) begin failures++; $display("FAIL fetch_ready got=%b want=11", {pc_wrt, ir_wrt}); end
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic test_addi();
    int d, mc; logic r, b, n, mw; logic [1:0] w, j;
    exec_instr(4'h1, 4'h0, 0, 0, 1'b1, d, r, w, b, n, j, mw, mc);
    checks++;
    if (d !== 4) begin failures++; $display("FAIL addi_latency got=%0d want=4", d); end
    checks++;
    if ({r, w} !== 3'b101) begin failures++; $display("FAIL addi_wb got=%b want=101", {r, w}); end
    checks++;
    if (instr_done !== 1'b0) begin failures++; $display("FAIL addi_pulse got=%b want=0", instr_done); end
    checks++;
    if (retired !== 32'(exp_retired)) begin failures++; $display("FAIL addi_retired got=%0d want=%0d", retired, exp_retired); end
  endtask

  task automatic test_classes();
    logic [3:0] t_op  [8] = '{4'h0, 4'h0, 4'h0, 4'hC, 4'hF, 4'h8, 4'h4, 4'hA};
    logic [3:0] t_fn  [8] = '{4'h0, 4'h6, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
    int         t_cyc [8] = '{4, 3, 4, 4, 4, 3, 3, 4};
    logic [4:0] t_res [8] = '{5'b10100, 5'b11000, 5'b00010, 5'b10100, 5'b10100,
                              5'b11100, 5'b00001, 5'b10100};
    int d, mc; logic r, b, n, mw; logic [1:0] w, j;
    for (int i = 0; i < 8; i++) begin
      exec_instr(t_op[i], t_fn[i], 0, 0, 1'b0, d, r, w, b, n, j, mw, mc);
      checks++;
      if (d !== t_cyc[i]) begin failures++; $display("FAIL class%0d_latency got=%0d want=%0d", i, d, t_cyc[i]); end
      checks++;
      if ({r, w, j} !== t_res[i]) begin failures++; $display("FAIL class%0d_ctrl got=%b want=%b", i, {r, w, j}, t_res[i]); end
    end
  endtask

  task automatic test_branch();
    int d, mc; logic r, b, n, mw; logic [1:0] w, j;
    exec_instr(4'h3, 4'h0, 0, 0, 1'b0, d, r, w, b, n, j, mw, mc);
    checks++;
    if ({d == 3, b, n, r} !== 4'b1110) begin failures++; $display("FAIL bne got=%0d/%b want=3/110", d, {b, n, r}); end
    exec_instr(4'h2, 4'h0, 0, 0, 1'b0, d, r, w, b, n, j, mw, mc);
    checks++;
    if ({d == 3, b, n, r} !== 4'b1100) begin failures++; $display("FAIL beq got=%0d/%b want=3/100", d, {b, n, r}); end
  endtask

  task automatic test_mem();
    int d, mc; logic r, b, n, mw; logic [1:0] w, j;
    exec_instr(4'h5, 4'h0, 0, 3, 1'b0, d, r, w, b, n, j, mw, mc);
    checks++;
    if (d !== 8) begin failures++; $display("FAIL lw_latency got=%0d want=8", d); end
    checks++;
    if ({r, w, mc[3:0]} !== 7'b1000100) begin failures++; $display("FAIL lw_ctrl got=%b want=1000100", {r, w, mc[3:0]}); end
    exec_instr(4'h6, 4'h0, 2, 1, 1'b0, d, r, w, b, n, j, mw, mc);
    checks++;
    if (d !== 7) begin failures++; $display("FAIL sw_latency got=%0d want=7", d); end
    checks++;
    if ({mw, r, mc[3:0]} !== 6'b100010) begin failures++; $display("FAIL sw_ctrl got=%b want=100010", {mw, r, mc[3:0]}); end
    checks++;
    if (retired !== 32'(exp_retired)) begin failures++; $display("FAIL mem_retired got=%0d want=%0d", retired, exp_retired); end
  endtask

  task automatic test_trap();
    op = 4'h7; func = 4'h0; mem_ready = 1'b1;
    #1; step();
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL trap_decode got=%b want=0", illegal); end
    step();
    for (int c = 0; c < 5; c++) begin
      mem_ready = c[0]; op = 4'h1;
      #1;
      checks++;
      if ({illegal, enables} !== 12'h800) begin
        failures++; $display("FAIL trap_cycle%0d got=%h want=800", c + 3, {illegal, enables});
      end
      step();
    end
    checks++;
    if (retired !== 32'(exp_retired)) begin failures++; $display("FAIL trap_retired got=%0d want=%0d", retired, exp_retired); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d, mc; logic r, b, n, mw; logic [1:0] w, j;
    do_reset();
    exec_instr(4'h1, 4'h0, 0, 0, 1'b0, d, r, w, b, n, j, mw, mc);
    op = 4'h5; func = 4'h0; mem_ready = 1'b1;
    step(); step();
    mem_ready = 1'b0;
    step();
    #1;
    checks++;
    if ({mem_req, mem_adrs_slct} !== 2'b11) begin failures++; $display("FAIL mid_in_memrd got=%b want=11", {mem_req, mem_adrs_slct}); end
    reset = 1'b0;
    #1;
    checks++;
    if ({all_out, retired} !== 57'd0) begin failures++; $display("FAIL mid_async got=%h/%0d want=0/0", all_out, retired); end
    step();
    checks++;
    if ({all_out, retired} !== 57'd0) begin failures++; $display("FAIL mid_held got=%h/%0d want=0/0", all_out, retired); end
    reset = 1'b1; op = 4'h1;
    exp_retired = 0;
    #1;
    checks++;
    if ({mem_req, mem_adrs_slct} !== 2'b10) begin failures++; $display("FAIL mid_fetch got=%b want=10", {mem_req, mem_adrs_slct}); end
    exec_instr(4'h1, 4'h0, 0, 0, 1'b0, d, r, w, b, n, j, mw, mc);
    checks++;
    if (d !== 4 || retired !== 32'd1) begin failures++; $display("FAIL mid_restart got=%0d/%0d want=4/1", d, retired); end
  endtask

  task automatic test_back_to_back();
    int d, mc; logic r, b, n, mw; logic [1:0] w, j;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exec_instr(4'h8, 4'h0, 0, 0, 1'b0, d, r, w, b, n, j, mw, mc);
      if (d != 3) bad++;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL b2b_latency got=%0d bad want=0", bad); end
    checks++;
    if (retired !== 32'd17) begin failures++; $display("FAIL b2b_retired32 got=%0d want=17", retired); end
    checks++;
    if (d4_retired !== 4'd1) begin failures++; $display("FAIL b2b_wrap got=%0d want=1", d4_retired); end
  endtask

  initial begin
    #2;
    test_reset();
    test_addi();
    test_classes();
    test_branch();
    test_mem();
    test_trap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
